// File: rtl/fpu_pkg.sv
// Shared definitions for the FP ALU issue path: op codes, unit count and
// dispatcher state encoding.
package fpu_pkg;

   localparam int NUM_UNITS = 5;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_CMP = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } disp_state_e;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_CMP;
   endfunction

   // One-hot unit mask for an op; all-zero for illegal codes.
   function automatic logic [NUM_UNITS-1:0] op_mask(input logic [2:0] op);
      logic [NUM_UNITS-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (op == 3'(i)) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/fpu_dispatch_watchdog.sv
// Unit-response watchdog: counts WAIT cycles and flags expiry on the
// TIMEOUT-th cycle without a response. Used only with FPU_DISPATCH_WATCHDOG_EN.
module fpu_dispatch_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic run_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expire_o = run_i && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (run_i && !expire_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fpu_dispatcher.sv
// Issue-side front end of the FP ALU: latches one request, strobes the selected
// unit, waits for its done and presents the op as result-select. Optional
// watchdog enabled by FPU_DISPATCH_WATCHDOG_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | in_ready high, waiting for a request
// ST_ISSUE | start strobe to the selected unit is high this cycle
// ST_WAIT  | waiting on done of the selected unit only
// ST_RESP  | out_valid held until the consumer accepts
module fpu_dispatcher
   import fpu_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [4:0]  u_start,
   output logic [31:0] u_a,
   output logic [31:0] u_b,
   input  logic [4:0]  u_done,
   output logic [2:0]  sel_op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        err
);

   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("fpu_dispatcher: TIMEOUT must be at least 2");
   end

   disp_state_e state_q, state_d;

   logic [2:0]           op_q, op_d;
   logic [31:0]          a_q, a_d;
   logic [31:0]          b_q, b_d;
   logic [NUM_UNITS-1:0] start_q, start_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic                 err_q, err_d;

   logic done_sel;
   logic wd_expire;

   assign done_sel = |(u_done & op_mask(op_q));

`ifdef FPU_DISPATCH_WATCHDOG_EN
   fpu_dispatch_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (state_q == ST_ISSUE),
      .run_i    (state_q == ST_WAIT),
      .expire_o (wd_expire)
   );
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         start_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         start_q     <= start_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (in_valid && op_legal(in_op)) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            // A done coinciding with watchdog expiry still completes the op.
            if (done_sel)       state_d = ST_RESP;
            else if (wd_expire) state_d = ST_IDLE;
         end
         ST_RESP:  if (out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      start_d     = '0;
      err_d       = 1'b0;
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_RESP);
      if (state_q == ST_IDLE && in_valid) begin
         op_d = in_op;
         a_d  = in_a;
         b_d  = in_b;
         if (op_legal(in_op)) start_d = op_mask(in_op);
         else                 err_d   = 1'b1;
      end
      if (state_q == ST_WAIT && !done_sel && wd_expire) err_d = 1'b1;
   end

   assign in_ready  = in_ready_q;
   assign u_start   = start_q;
   assign u_a       = a_q;
   assign u_b       = b_q;
   assign sel_op    = op_q;
   assign out_valid = out_valid_q;
   assign err       = err_q;

endmodule

// File: tb/tb_fpu_dispatcher.sv
// Self-checking bench for fpu_dispatcher: directed scenarios plus randomized
// transactions checked against cycle timing derived from the dispatch rules.
module tb_fpu_dispatcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [4:0]  u_start;
   logic [31:0] u_a;
   logic [31:0] u_b;
   logic [4:0]  u_done;
   logic [2:0]  sel_op;
   logic        out_valid;
   logic        out_ready;
   logic        err;

   int total = 0;
   int bad   = 0;

   fpu_dispatcher #(.TIMEOUT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .u_start   (u_start),
      .u_a       (u_a),
      .u_b       (u_b),
      .u_done    (u_done),
      .sel_op    (sel_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
      u_done = '0; out_ready = 1'b0;
      tick(); tick();
      total++;
      if ({in_ready, u_start, out_valid, err, sel_op} !== 11'b1_00000_0_0_000 || u_a !== 32'h0 || u_b !== 32'h0) begin
         bad++;
         $display("FAIL reset_held rdy=%b st=%b ov=%b err=%b sel=%h a=%h b=%h, want rdy=1 others 0",
                  in_ready, u_start, out_valid, err, sel_op, u_a, u_b);
      end
      rst = 1'b0;
      tick();
      total++;
      if ({in_ready, u_start, out_valid, err, sel_op} !== 11'b1_00000_0_0_000 || u_a !== 32'h0) begin
         bad++;
         $display("FAIL reset_released rdy=%b st=%b ov=%b err=%b sel=%h, want rdy=1 others 0",
                  in_ready, u_start, out_valid, err, sel_op);
      end
   endtask

   task automatic test_mul();
      in_valid = 1'b1; in_op = 3'b010; in_a = 32'h40400000; in_b = 32'h40000000;
      tick();
      in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
      total++;
      if (u_start !== 5'b00100 || in_ready !== 1'b0 || u_a !== 32'h40400000 || u_b !== 32'h40000000) begin
         bad++;
         $display("FAIL mul_start st=%b rdy=%b a=%h b=%h, want st=00100 rdy=0 a=40400000 b=40000000",
                  u_start, in_ready, u_a, u_b);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (u_start !== 5'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mul_wait%0d st=%b ov=%b, want st=00000 ov=0", i, u_start, out_valid);
         end
      end
      tick();
      u_done = 5'b00100;
      tick();
      u_done = '0;
      total++;
      if (out_valid !== 1'b1 || sel_op !== 3'b010) begin
         bad++;
         $display("FAIL mul_resp ov=%b sel=%b, want ov=1 sel=010", out_valid, sel_op);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (out_valid !== 1'b1 || sel_op !== 3'b010 || u_a !== 32'h40400000 || u_b !== 32'h40000000) begin
            bad++;
            $display("FAIL mul_hold%0d ov=%b sel=%b a=%h b=%h, want ov=1 sel=010 operands held",
                     i, out_valid, sel_op, u_a, u_b);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL mul_handshake ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_illegal();
      in_valid = 1'b1; in_op = 3'b110; in_a = 32'h12345678; in_b = 32'h9abcdef0;
      tick();
      in_valid = 1'b0;
      total++;
      if (err !== 1'b1 || u_start !== 5'b0 || in_ready !== 1'b1 || sel_op !== 3'b110) begin
         bad++;
         $display("FAIL illegal_err err=%b st=%b rdy=%b sel=%b, want err=1 st=00000 rdy=1 sel=110",
                  err, u_start, in_ready, sel_op);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (err !== 1'b0 || u_start !== 5'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL illegal_after%0d err=%b st=%b rdy=%b ov=%b, want err=0 st=0 rdy=1 ov=0",
                     i, err, u_start, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_ignore_other_done();
      in_valid = 1'b1; in_op = 3'b011; in_a = $urandom; in_b = $urandom;
      tick();
      in_valid = 1'b0;
      u_done = 5'b01000;
      tick();
      u_done = 5'b00101;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL div_done_in_issue ov=%b, want 0", out_valid);
      end
      tick();
      u_done = '0;
      tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL div_other_done ov=%b rdy=%b, want ov=0 rdy=0", out_valid, in_ready);
      end
      u_done = 5'b01000;
      tick();
      u_done = '0;
      total++;
      if (out_valid !== 1'b1 || sel_op !== 3'b011) begin
         bad++;
         $display("FAIL div_resp ov=%b sel=%b, want ov=1 sel=011", out_valid, sel_op);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      in_valid = 1'b1; in_op = 3'b001; in_a = $urandom; in_b = $urandom;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({in_ready, u_start, out_valid, err, sel_op} !== 11'b1_00000_0_0_000 || u_a !== 32'h0 || u_b !== 32'h0) begin
         bad++;
         $display("FAIL rst_mid_wait rdy=%b st=%b ov=%b err=%b sel=%h a=%h b=%h, want reset values",
                  in_ready, u_start, out_valid, err, sel_op, u_a, u_b);
      end
      tick();
      rst = 1'b0;
      u_done = 5'b00010;
      tick();
      u_done = '0;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || sel_op !== 3'b000) begin
            bad++;
            $display("FAIL late_done%0d ov=%b rdy=%b sel=%b, want ov=0 rdy=1 sel=000",
                     i, out_valid, in_ready, sel_op);
         end
      end
   endtask

`ifdef FPU_DISPATCH_WATCHDOG_EN
   task automatic test_watchdog();
      in_valid = 1'b1; in_op = 3'b100; in_a = $urandom; in_b = $urandom;
      tick();
      in_valid = 1'b0;
      tick();
      for (int i = 1; i <= 8; i++) begin
         total++;
         if (err !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL wd_wait%0d err=%b ov=%b, want err=0 ov=0", i, err, out_valid);
         end
         tick();
      end
      total++;
      if (err !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL wd_expire err=%b rdy=%b ov=%b, want err=1 rdy=1 ov=0", err, in_ready, out_valid);
      end
      tick();
      total++;
      if (err !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL wd_after err=%b ov=%b, want err=0 ov=0", err, out_valid);
      end
      in_valid = 1'b1; in_op = 3'b000; in_a = 32'h3f800000; in_b = 32'h3f800000;
      tick();
      in_valid = 1'b0;
      tick();
      u_done = 5'b00001;
      tick();
      u_done = '0;
      total++;
      if (out_valid !== 1'b1 || sel_op !== 3'b000 || err !== 1'b0) begin
         bad++;
         $display("FAIL wd_next_add ov=%b sel=%b err=%b, want ov=1 sel=000 err=0", out_valid, sel_op, err);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 3'b010; in_a = $urandom; in_b = $urandom;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      u_done = 5'b00100;
      tick();
      u_done = '0;
      total++;
      if (out_valid !== 1'b1 || err !== 1'b0) begin
         bad++;
         $display("FAIL wd_coincide ov=%b err=%b, want ov=1 err=0", out_valid, err);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask
`else
   task automatic test_watchdog();
      in_valid = 1'b1; in_op = 3'b100; in_a = $urandom; in_b = $urandom;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         total++;
         if (err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL nowd_wait%0d err=%b ov=%b rdy=%b, want all 0", i, err, out_valid, in_ready);
         end
      end
      u_done = 5'b10000;
      tick();
      u_done = '0;
      total++;
      if (out_valid !== 1'b1 || sel_op !== 3'b100) begin
         bad++;
         $display("FAIL nowd_resp ov=%b sel=%b, want ov=1 sel=100", out_valid, sel_op);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask
`endif

   task automatic test_back_to_back();
      logic [31:0] a1, b1, a2, b2;
      a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
      out_ready = 1'b1;
      in_valid = 1'b1; in_op = 3'b000; in_a = a1; in_b = b1;
      tick();
      in_a = a2; in_b = b2;
      tick();
      u_done = 5'b00001;
      tick();
      u_done = '0;
      total++;
      if (out_valid !== 1'b1 || sel_op !== 3'b000 || u_a !== a1 || u_b !== b1) begin
         bad++;
         $display("FAIL b2b_first ov=%b sel=%b a=%h b=%h, want ov=1 sel=000 a=%h b=%h",
                  out_valid, sel_op, u_a, u_b, a1, b1);
      end
      tick();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || u_a !== a1) begin
         bad++;
         $display("FAIL b2b_gap rdy=%b ov=%b a=%h, want rdy=1 ov=0 a=%h", in_ready, out_valid, u_a, a1);
      end
      tick();
      in_valid = 1'b0;
      total++;
      if (u_start !== 5'b00001 || u_a !== a2 || u_b !== b2) begin
         bad++;
         $display("FAIL b2b_second st=%b a=%h b=%h, want st=00001 a=%h b=%h", u_start, u_a, u_b, a2, b2);
      end
      tick();
      u_done = 5'b00001;
      tick();
      u_done = '0;
      total++;
      if (out_valid !== 1'b1 || u_a !== a2) begin
         bad++;
         $display("FAIL b2b_second_resp ov=%b a=%h, want ov=1 a=%h", out_valid, u_a, a2);
      end
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [4:0]  mask, exp_st;
      logic        exp_ov, exp_rdy;
      int          lat, rd, last;
      for (int t = 0; t < 40; t++) begin
         op  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
         a   = $urandom;
         b   = $urandom;
         lat = $urandom_range(1, 5);
         rd  = $urandom_range(0, 3);
         in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
         tick();
         in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
         if (op > 3'd4) begin
            total++;
            if (err !== 1'b1 || u_start !== 5'b0 || in_ready !== 1'b1 || sel_op !== op || u_a !== a) begin
               bad++;
               $display("FAIL rnd%0d_illegal err=%b st=%b rdy=%b sel=%h, want err=1 st=0 rdy=1 sel=%h",
                        t, err, u_start, in_ready, sel_op, op);
            end
            tick();
            continue;
         end
         mask = 5'b00001 << op;
         last = lat + 3 + rd;
         for (int c = 1; c <= last; c++) begin
            exp_st  = (c == 1) ? mask : 5'b0;
            exp_ov  = (c >= lat + 2) && (c <= lat + 2 + rd);
            exp_rdy = (c == last);
            total++;
            if ({u_start, out_valid, in_ready, err} !== {exp_st, exp_ov, exp_rdy, 1'b0} ||
                sel_op !== op || u_a !== a || u_b !== b) begin
               bad++;
               $display("FAIL rnd%0d_c%0d op=%h lat=%0d st=%b ov=%b rdy=%b err=%b sel=%h, want st=%b ov=%b rdy=%b err=0 sel=%h",
                        t, c, op, lat, u_start, out_valid, in_ready, err, sel_op, exp_st, exp_ov, exp_rdy, op);
            end
            if (c == last) break;
            u_done = 5'($urandom) & ~mask;
            if (c == lat + 1 || (c == 1 && $urandom_range(0, 1) == 1)) u_done = u_done | mask;
            out_ready = (c < lat + 2) ? 1'($urandom_range(0, 1)) : (c == lat + 2 + rd);
            tick();
         end
         u_done = '0;
         out_ready = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_illegal();
      test_ignore_other_done();
      test_reset_mid_wait();
      test_watchdog();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
